// File: rtl/obuf_pkg.sv
// Shared definitions for the output-buffer drain path: default geometry and drain FSM states.
package obuf_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned RES_W          = 2 * DEF_DATA_WIDTH;
  localparam int unsigned DEF_LANES      = 2;
  localparam int unsigned DEF_FRAME_LEN  = 9;
  localparam int unsigned DEF_CNT_WIDTH  = 4;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    TAIL
  } drain_state_t;

endpackage

// File: rtl/obuf_drain_outreg.sv
// Single-entry valid/ready output register carrying a packed beat with keep and last.
module obuf_drain_outreg #(
  parameter int unsigned DW = 32,
  parameter int unsigned KW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic [KW-1:0] in_keep,
  input  logic          in_last,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic [KW-1:0] out_keep,
  output logic          out_last,
  input  logic          out_ready
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic [KW-1:0] keep_q, keep_d;
  logic          last_q, last_d;

  always_comb begin
    in_ready = ~valid_q | out_ready;
    valid_d  = valid_q;
    data_d   = data_q;
    keep_d   = keep_q;
    last_d   = last_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
        keep_d = in_keep;
        last_d = in_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_keep  = keep_q;
  assign out_last  = last_q;

endmodule

// File: rtl/obuf_drain.sv
// Drains the output-buffer FIFO and packs results into framed valid/ready beats.
// Optional build macro OBUF_DRAIN_RELU_EN clamps negative results to zero at lane capture.
module obuf_drain
  import obuf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned LANES      = DEF_LANES,
  parameter int unsigned FRAME_LEN  = DEF_FRAME_LEN,
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          fifo_empty,
  output logic                          fifo_rd_en,
  input  logic [2*DATA_WIDTH-1:0]       fifo_rdata,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [LANES*2*DATA_WIDTH-1:0] m_data,
  output logic [LANES-1:0]              m_keep,
  output logic                          m_last,
  output logic [15:0]                   frame_cnt,
  output logic                          busy
);

  localparam int unsigned ResW = 2 * DATA_WIDTH;
  localparam int unsigned LcW  = $clog2(LANES + 1);
  localparam int unsigned FrW  = LcW + 1;
  localparam logic [CNT_WIDTH-1:0] FrameLenC = CNT_WIDTH'(FRAME_LEN);
  localparam logic [LcW-1:0]       LanesC    = LcW'(LANES);

  drain_state_t                     state_q, state_d;
  logic [LcW-1:0]                   lane_cnt_q, lane_cnt_d;
  logic [CNT_WIDTH-1:0]             issued_q, issued_d;
  logic                             rd_pend_q, rd_pend_d;
  logic [LANES-1:0][ResW-1:0]       pack_q, pack_d;
  logic [15:0]                      frame_cnt_q, frame_cnt_d;

  logic                   frame_issued, pack_ready, load_ready, flush, last_flush, pop;
  logic [FrW-1:0]         free;
  logic [ResW-1:0]        cap_data;
  logic [LcW-1:0]         base;
  logic [LANES*ResW-1:0]  flush_data;
  logic [LANES-1:0]       flush_keep;

  always_comb begin
    frame_issued = (issued_q == FrameLenC);
    pack_ready   = (lane_cnt_q == LanesC) ||
                   (frame_issued && !rd_pend_q && (lane_cnt_q != '0));
    flush        = pack_ready && load_ready;
    // Once the frame is fully issued and nothing is in flight, any flush carries its final result.
    last_flush   = flush && frame_issued && !rd_pend_q;
    free         = FrW'(LANES) - FrW'(lane_cnt_q) - FrW'(rd_pend_q) +
                   (flush ? FrW'(lane_cnt_q) : '0);
    pop          = en && !fifo_empty && (state_q == DRAIN) && !frame_issued && (free != '0);
  end

`ifdef OBUF_DRAIN_RELU_EN
  assign cap_data = fifo_rdata[ResW-1] ? '0 : fifo_rdata;
`else
  assign cap_data = fifo_rdata;
`endif

  always_comb begin
    flush_data = '0;
    flush_keep = '0;
    for (int i = 0; i < LANES; i++) begin
      flush_keep[i] = (LcW'(i) < lane_cnt_q);
      if (flush_keep[i]) flush_data[i*ResW +: ResW] = pack_q[i];
    end
  end

  always_comb begin
    pack_d     = pack_q;
    lane_cnt_d = lane_cnt_q;
    base       = lane_cnt_q;
    if (flush) begin
      pack_d     = '0;
      lane_cnt_d = '0;
      base       = '0;
    end
    if (rd_pend_q) begin
      for (int i = 0; i < LANES; i++) begin
        if (LcW'(i) == base) pack_d[i] = cap_data;
      end
      lane_cnt_d = base + LcW'(1);
    end

    rd_pend_d   = pop;
    issued_d    = issued_q + CNT_WIDTH'(pop);
    if (last_flush) issued_d = '0;
    frame_cnt_d = frame_cnt_q + 16'(m_valid & m_ready & m_last);

    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en) state_d = DRAIN;
      DRAIN: begin
        if (frame_issued)           state_d = TAIL;
        else if (!en && !rd_pend_q) state_d = IDLE;
      end
      TAIL:    if (last_flush) state_d = en ? DRAIN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lane_cnt_q  <= '0;
      issued_q    <= '0;
      rd_pend_q   <= 1'b0;
      pack_q      <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      lane_cnt_q  <= lane_cnt_d;
      issued_q    <= issued_d;
      rd_pend_q   <= rd_pend_d;
      pack_q      <= pack_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  obuf_drain_outreg #(
    .DW(LANES * ResW),
    .KW(LANES)
  ) u_outreg (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (flush),
    .in_data  (flush_data),
    .in_keep  (flush_keep),
    .in_last  (last_flush),
    .in_ready (load_ready),
    .out_valid(m_valid),
    .out_data (m_data),
    .out_keep (m_keep),
    .out_last (m_last),
    .out_ready(m_ready)
  );

  assign fifo_rd_en = pop;
  assign frame_cnt  = frame_cnt_q;
  assign busy       = rd_pend_q | (lane_cnt_q != '0) | m_valid;

endmodule
